// File: rtl/crc16_stream_engine.sv
// Framed CRC-16 engine: folds a beat stream (valid/ready, partial last beat)
// into a CRC register and presents CRC, byte count and check result per frame.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  beat handshake (in_ready decoded from state and rst)
//   in_data         beat, byte 0 in the top byte, MSB-first bit order
//   in_last         last beat of the frame
//   in_nbytes       valid bytes on the last beat (0 or >NB means NB)
//   in_check        frame mode on the first beat: 0 generate, 1 check
//   in_abort        drop the frame in progress
//   res_valid/ready result handshake
//   res_crc         final register XOR XOROUT
//   res_ok          check mode: final register is zero
//   res_len         bytes accepted in the frame, saturating
module crc16_stream_engine #(
  parameter int unsigned DATA_W = 32,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic [$clog2(DATA_W/8):0] in_nbytes,
  input  logic                      in_check,
  input  logic                      in_abort,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [15:0]               res_crc,
  output logic                      res_ok,
  output logic [15:0]               res_len
);

  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned NBW = $clog2(NB) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t      state, state_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        mode_q, mode_d;
  logic        load_res;
  logic        accept;

  logic [NBW-1:0] nb_eff;
  logic [15:0]    fold_crc;
  logic [16:0]    len_sum;
  logic [15:0]    len_sat;
  logic           mode_eff;

  // One MSB-first byte step of the CRC register.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ POLY) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign in_ready = !rst && (state != DONE);
  assign accept   = in_valid && in_ready;

  // Valid-byte count of the current beat; only the last beat can be partial.
  always_comb begin
    nb_eff = NBW'(NB);
    if (in_last && (in_nbytes != '0) && (in_nbytes <= NBW'(NB))) begin
      nb_eff = in_nbytes;
    end
  end

  // Byte-parallel fold; bytes past nb_eff bypass their stage untouched.
  always_comb begin
    fold_crc = crc_q;
    for (int unsigned i = 0; i < NB; i++) begin
      if (NBW'(i) < nb_eff) begin
        fold_crc = crc_byte(fold_crc, in_data[DATA_W-1-8*i -: 8]);
      end
    end
  end

  // Saturating length accumulation.
  always_comb begin
    len_sum = {1'b0, len_q} + 17'(nb_eff);
    len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  end

  // The first beat's mode is not latched yet when it is also the last beat.
  assign mode_eff = (state == IDLE) ? in_check : mode_q;

  // Next-state and datapath control.
  always_comb begin
    state_d  = state;
    crc_d    = crc_q;
    len_d    = len_q;
    mode_d   = mode_q;
    load_res = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          crc_d  = fold_crc;
          len_d  = len_sat;
          mode_d = in_check;
          if (in_last) begin
            state_d  = DONE;
            load_res = 1'b1;
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (in_abort) begin
          state_d = IDLE;
          crc_d   = INIT;
          len_d   = 16'h0000;
          mode_d  = 1'b0;
        end else if (accept) begin
          crc_d = fold_crc;
          len_d = len_sat;
          if (in_last) begin
            state_d  = DONE;
            load_res = 1'b1;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          crc_d   = INIT;
          len_d   = 16'h0000;
          mode_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        crc_d   = INIT;
        len_d   = 16'h0000;
        mode_d  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Running CRC, length, mode and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= INIT;
      len_q     <= 16'h0000;
      mode_q    <= 1'b0;
      res_valid <= 1'b0;
      res_crc   <= 16'h0000;
      res_ok    <= 1'b0;
      res_len   <= 16'h0000;
    end else begin
      crc_q     <= crc_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      res_valid <= (state_d == DONE);
      if (load_res) begin
        res_crc <= fold_crc ^ XOROUT;
        res_ok  <= mode_eff && (fold_crc == 16'h0000);
        res_len <= len_sat;
      end
    end
  end

endmodule

// File: tb/tb_crc16_stream_engine.sv
// Self-checking bench: two engines (DATA_W=8 and DATA_W=32) driven with
// directed and randomized frames; a bit-serial CRC model predicts each result.
module tb_crc16_stream_engine;

  localparam logic [15:0] POLY   = 16'h1021;
  localparam logic [15:0] INIT   = 16'hFFFF;
  localparam logic [15:0] XOROUT = 16'h0000;

  typedef struct {
    logic [15:0] crc;
    logic [15:0] len;
    logic        ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v8 = 0, r8, last8 = 0, chk8 = 0, ab8 = 0, rv8, rr8 = 1, ok8;
  logic [7:0]  dat8 = 0;
  logic [0:0]  nb8 = 0;
  logic [15:0] crc8, len8;

  logic        v32 = 0, r32, last32 = 0, chk32 = 0, ab32 = 0, rv32, rr32 = 1, ok32;
  logic [31:0] dat32 = 0;
  logic [2:0]  nb32 = 0;
  logic [15:0] crc32, len32;

  int total = 0;
  int bad   = 0;
  bit rand_rr = 0;

  logic [7:0] frame_q[$];
  exp_t exp8[$];
  exp_t exp32[$];

  always #5 clk = ~clk;

  crc16_stream_engine #(.DATA_W(8), .POLY(POLY), .INIT(INIT), .XOROUT(XOROUT)) d8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_data(dat8), .in_last(last8),
    .in_nbytes(nb8), .in_check(chk8), .in_abort(ab8), .res_valid(rv8), .res_ready(rr8),
    .res_crc(crc8), .res_ok(ok8), .res_len(len8));

  crc16_stream_engine #(.DATA_W(32), .POLY(POLY), .INIT(INIT), .XOROUT(XOROUT)) d32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_data(dat32), .in_last(last32),
    .in_nbytes(nb32), .in_check(chk32), .in_abort(ab32), .res_valid(rv32), .res_ready(rr32),
    .res_crc(crc32), .res_ok(ok32), .res_len(len32));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bit-serial reference CRC over the whole frame, straight from the polynomial.
  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    logic        fb;
    c = INIT;
    foreach (frame_q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ frame_q[i][b];
        c  = {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic load_str(input string s);
    frame_q.delete();
    for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
  endtask

  task automatic set_in(input int w, input logic v, input logic [31:0] d, input logic l,
                        input logic [2:0] nb, input logic c, input logic a);
    if (w == 8) begin
      v8 = v; dat8 = d[7:0]; last8 = l; nb8 = nb[0]; chk8 = c; ab8 = a;
    end else begin
      v32 = v; dat32 = d; last32 = l; nb32 = nb; chk32 = c; ab32 = a;
    end
  endtask

  // Returns at the negedge before the accepting edge.
  task automatic wait_accept(input int w);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if ((w == 8) ? r8 : r32) break;
      k++;
      if (k > 300) begin
        total++; bad++;
        $display("FAIL accept_timeout dut%0d actual=no_ready required=ready", w);
        break;
      end
    end
  endtask

  // kill: 0 none, 1 abort on beat kill_at (with that beat), 2 reset before beat kill_at.
  task automatic send_frame(input int w, input bit chk_m, input int kill, input int kill_at,
                            input int gap_max, input int fill);
    int n, nbeats, rem;
    logic [31:0] d;
    logic [2:0]  nb;
    logic        last;
    logic [7:0]  byt;
    exp_t e;
    n = frame_q.size();
    nbeats = (w == 8) ? n : (n + 3) / 4;
    if (kill == 0) begin
      e.crc = crc_ref() ^ XOROUT;
      e.len = 16'(n);
      e.ok  = chk_m && (crc_ref() == 16'h0000);
      if (w == 8) exp8.push_back(e); else exp32.push_back(e);
    end
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      if (kill == 2 && b == kill_at) begin
        rst = 1'b1;
        repeat (2) begin
          @(negedge clk);
          chk("ready_in_reset", (w == 8) ? r8 : r32, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      last = (b == nbeats - 1);
      d  = 32'h0;
      nb = 3'($urandom_range(0, 7));
      if (w == 8) begin
        d[7:0] = frame_q[b];
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (4 * b + k < n) byt = frame_q[4 * b + k];
          else if (fill == 0) byt = 8'h00;
          else if (fill == 1) byt = 8'hFF;
          else byt = 8'($urandom);
          d[31 - 8 * k -: 8] = byt;
        end
        if (last) begin
          rem = n - 4 * b;
          if (rem == 4) begin
            case ($urandom_range(0, 4))
              0: nb = 3'd0;
              1: nb = 3'd4;
              2: nb = 3'd5;
              3: nb = 3'd6;
              default: nb = 3'd7;
            endcase
          end else begin
            nb = 3'(rem);
          end
        end
      end
      set_in(w, 1'b1, d, last, nb, chk_m, (kill == 1 && b == kill_at));
      wait_accept(w);
      @(posedge clk); #1;
      set_in(w, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
      if (kill == 1 && b == kill_at) return;
      if (last) chk("result_latency", (w == 8) ? rv8 : rv32, 1);
    end
  endtask

  // Result scoreboard: every cycle with res_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rv8) begin
      if (exp8.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_res8 actual=res_valid required=none crc=%h", crc8);
      end else begin
        chk("res8_crc", crc8, exp8[0].crc);
        chk("res8_len", len8, exp8[0].len);
        chk("res8_ok", ok8, exp8[0].ok);
        if (rr8) void'(exp8.pop_front());
      end
    end
    if (rv32) begin
      if (exp32.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_res32 actual=res_valid required=none crc=%h", crc32);
      end else begin
        chk("res32_crc", crc32, exp32[0].crc);
        chk("res32_len", len32, exp32[0].len);
        chk("res32_ok", ok32, exp32[0].ok);
        if (rr32) void'(exp32.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rr) begin
        rr8  = 1'($urandom_range(0, 1));
        rr32 = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    exp_t e;
    logic [15:0] c;
    int n, w, nbeats, kill, kill_at;
    bit cm;

    // Pin the model against known CRC-16/CCITT-FALSE values.
    load_str("123456789");
    chk("model_29b1", crc_ref(), 16'h29B1);
    frame_q.delete(); frame_q.push_back(8'h00);
    chk("model_e1f0", crc_ref(), 16'hE1F0);
    load_str("123456789"); frame_q.push_back(8'h29); frame_q.push_back(8'hB1);
    chk("model_residue", crc_ref(), 16'h0000);

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready8", r8, 0);
    chk("rst_ready32", r32, 0);
    chk("rst_rv8", rv8, 0);
    chk("rst_rv32", rv32, 0);
    chk("rst_crc8", crc8, 16'h0000);
    chk("rst_crc32", crc32, 16'h0000);
    chk("rst_len32", len32, 16'h0000);
    chk("rst_ok32", ok32, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready8", r8, 1);
    chk("post_rst_rv8", rv8, 0);
    chk("post_rst_crc32", crc32, 16'h0000);
    @(posedge clk); #1;

    // Generate mode, one byte per beat and four bytes per beat with fillers.
    load_str("123456789");
    send_frame(8, 0, 0, 0, 0, 0);
    @(negedge clk); chk("lit_crc8", crc8, 16'h29B1); chk("lit_len8", len8, 16'd9);
    @(posedge clk); #1;
    send_frame(32, 0, 0, 0, 0, 0);
    @(negedge clk); chk("lit_crc32_zero_fill", crc32, 16'h29B1);
    @(posedge clk); #1;
    send_frame(32, 0, 0, 0, 1, 1);
    @(negedge clk); chk("lit_crc32_ones_fill", crc32, 16'h29B1); chk("lit_len32", len32, 16'd9);
    @(posedge clk); #1;

    // Check mode, intact and with bit 0 of byte 3 flipped.
    load_str("123456789"); frame_q.push_back(8'h29); frame_q.push_back(8'hB1);
    send_frame(8, 1, 0, 0, 1, 0);
    @(negedge clk); chk("lit_check_ok", ok8, 1); chk("lit_check_len", len8, 16'd11);
    @(posedge clk); #1;
    frame_q[3] = frame_q[3] ^ 8'h01;
    send_frame(8, 1, 0, 0, 1, 0);
    @(negedge clk); chk("lit_check_bad", ok8, 0);
    @(posedge clk); #1;
    load_str("123456789"); frame_q.push_back(8'h29); frame_q.push_back(8'hB1);
    send_frame(32, 1, 0, 0, 1, 2);

    // Single-byte frame held in DONE while a new beat waits.
    repeat (3) begin @(posedge clk); #1; end
    rr8 = 1'b0;
    frame_q.delete(); frame_q.push_back(8'h00);
    send_frame(8, 0, 0, 0, 0, 0);
    @(negedge clk); chk("lit_single_crc", crc8, 16'hE1F0); chk("lit_single_len", len8, 16'd1);
    e.crc = 16'hE1F0; e.len = 16'd1; e.ok = 1'b0;
    exp8.push_back(e);
    set_in(8, 1'b1, 32'h0, 1'b1, 3'd1, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_ready", r8, 0);
      chk("hold_valid", rv8, 1);
    end
    @(posedge clk); #1;
    rr8 = 1'b1;
    @(negedge clk); chk("handshake_cycle_ready", r8, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("bubble_then_ready", r8, 1);
    @(posedge clk); #1;
    set_in(8, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("held_beat_result", rv8, 1);
    @(posedge clk); #1;

    // Abort mid-frame, then a clean frame.
    load_str("123456789");
    send_frame(8, 0, 1, 4, 0, 0);
    send_frame(8, 0, 0, 0, 1, 0);
    repeat (4) begin @(posedge clk); #1; end
    // Reset mid-frame, then a clean frame.
    send_frame(8, 0, 2, 4, 0, 0);
    send_frame(8, 0, 0, 0, 1, 0);
    repeat (4) begin @(posedge clk); #1; end
    // Abort together with the last beat.
    send_frame(8, 0, 1, 8, 0, 0);
    @(negedge clk); chk("abort_last_ready", r8, 1); chk("abort_last_novalid", rv8, 0);
    @(posedge clk); #1;
    send_frame(32, 0, 1, 2, 0, 2);
    @(negedge clk); chk("abort_last32_ready", r32, 1);
    @(posedge clk); #1;

    // Randomized frames against the model.
    rand_rr = 1;
    for (int f = 0; f < 200; f++) begin
      w = ($urandom_range(0, 1) == 0) ? 8 : 32;
      n = $urandom_range(1, 24);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
      cm = ($urandom_range(0, 2) == 0);
      if (cm) begin
        c = crc_ref();
        frame_q.push_back(c[15:8]);
        frame_q.push_back(c[7:0]);
        if ($urandom_range(0, 3) == 0) begin
          n = $urandom_range(0, frame_q.size() - 1);
          frame_q[n] = frame_q[n] ^ 8'(1 << $urandom_range(0, 7));
        end
      end
      nbeats = (w == 8) ? frame_q.size() : (frame_q.size() + 3) / 4;
      kill = 0; kill_at = 0;
      if (nbeats >= 2 && $urandom_range(0, 7) == 0) begin
        kill = 1;
        kill_at = $urandom_range(1, nbeats - 1);
      end
      send_frame(w, cm, kill, kill_at, 2, 2);
    end
    rand_rr = 0;
    @(posedge clk); #1;
    rr8 = 1'b1; rr32 = 1'b1;

    begin
      int k;
      k = 0;
      while ((exp8.size() != 0 || exp32.size() != 0) && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      total++;
      if (exp8.size() != 0 || exp32.size() != 0) begin
        bad++;
        $display("FAIL drain actual=%0d/%0d pending required=0", exp8.size(), exp32.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc16_stream_engine.md
# crc16_stream_engine

Parametrised, framed CRC-16 engine (polynomial x^16+x^12+x^5+1 by default) for the SSD controller datapath. It accepts a packet as a stream of DATA_W-bit beats with valid/ready flow control and a partial final beat. At the end of each frame it presents the CRC, the frame byte count and, in check mode, a pass/fail flag. It sits between the host/flash data movers and the buffer manager, and replaces single-width CRC registers that have no framing.

## Interface
Parameters:
- DATA_W, 32: beat width in bits; multiple of 8, range 8..128; NB = DATA_W/8 bytes per beat.
- POLY, 16'h1021: generator polynomial, implicit x^16 term.
- INIT, 16'hFFFF: CRC register value at the start of every frame.
- XOROUT, 16'h0000: value XORed onto the final register to form res_crc.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  engine can accept a beat.
- in_data  in  DATA_W  beat; byte 0 = in_data[DATA_W-1:DATA_W-8], processed first, MSB-first within each byte.
- in_last  in  1  beat is the last of the frame.
- in_nbytes  in  $clog2(NB)+1  valid bytes on the last beat, MSB-aligned. 0 or >NB is treated as NB. Ignored when in_last=0.
- in_check  in  1  frame mode, sampled on the first beat: 0 = generate, 1 = check (frame ends with its 2 CRC bytes, high byte first).
- in_abort  in  1  discard the frame in progress.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_crc  out  16  final register XOR XOROUT.
- res_ok  out  1  check mode: 1 when the final register equals 16'h0000. Generate mode: 0.
- res_len  out  16  bytes accepted in the frame, saturating at 16'hFFFF.

## Operation
- States: IDLE, ACTIVE, DONE.
  - IDLE: in_ready=1. An accepted beat folds into INIT and latches in_check. It goes to ACTIVE, or to DONE if in_last is set.
  - ACTIVE: in_ready=1. Each accepted beat folds into the running CRC. An accepted in_last goes to DONE.
  - DONE: in_ready=0, res_valid=1, all res_* held stable. On res_valid & res_ready go to IDLE and reload the CRC register with INIT.
- Folding is combinational over the valid bytes of the beat: NB parallel byte-update stages, each with a bypass mux. Bytes past in_nbytes on the last beat are skipped entirely, not folded as zeros.
- Length counter: adds the valid-byte count per accepted beat and saturates. It is cleared on entry to IDLE.
- in_abort:
  - In ACTIVE: return to IDLE; CRC, length and mode are discarded.
  - In the same cycle as an accepted beat: abort wins and the beat is dropped.
  - In IDLE or DONE: ignored.
- The check-mode residue is 16'h0000 only when XOROUT=0. Check mode with XOROUT≠0 compares against 16'h0000 anyway and is unsupported.

## Timing
- Beat accepted on a clk edge where in_valid & in_ready & !rst.
- res_valid rises the cycle after the last beat is accepted; latency is 1 cycle for any NB.
- Once the result handshake completes, in_ready returns the following cycle, so there is one bubble per frame. Sustained throughput is DATA_W bits per cycle within a frame.
- in_valid may be deasserted between beats indefinitely; CRC and length hold.
- Reset values while rst is high and on the cycle after:
  - state IDLE, in_ready=0 while rst=1;
  - res_valid=0, res_crc=16'h0000, res_ok=0, res_len=0;
  - internal CRC register = INIT.
- Reset mid-frame or during DONE discards everything. No result is emitted.
- All outputs are registered, except in_ready, which is decoded from state and rst.

## Test plan
- DATA_W=8, generate mode, ASCII "123456789", one byte per beat, in_last on 0x39 -> res_crc=16'h29B1, res_len=9, res_ok=0, res_valid 1 cycle after the last beat.
- DATA_W=32, beats 32'h31323334, 32'h35363738, 32'h39000000 (in_last, in_nbytes=1) -> res_crc=16'h29B1, res_len=9. Repeat with filler 32'h39FFFFFF -> same result.
- Check mode, DATA_W=8, "123456789" followed by 0x29, 0xB1 -> res_ok=1, res_crc=16'h0000, res_len=11. Flip bit 0 of byte 3 -> res_ok=0.
- Single-beat frame, DATA_W=8, byte 0x00 with in_last -> res_crc=16'hE1F0, res_len=1. Hold res_ready=0 for 5 cycles -> res_* stable and in_ready=0; an offered beat is not accepted until 1 cycle after the handshake.
- Abort after 4 bytes of "1234...", then a clean "123456789" frame -> 16'h29B1, res_len=9 (no contamination). Repeat using rst instead of in_abort -> same result, and no res_valid for the aborted frame.
- Abort asserted together with a valid in_last beat -> no res_valid. Engine returns to IDLE with in_ready=1.
